// File: rtl/des_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : des_key_sched_ctrl (with helper perm2)
// Purpose  : DES round-key sequencer: PC-1 load, per-round C/D rotation and a
//            PC-2 view of C/D presented one key per round over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================

module perm2 (
  input  logic [55:0] i_cd,
  output logic [47:0] o_key
);
  // DES numbering: o_key bit n+1 takes CD bit c_pc2[n]
  localparam int c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic w_unused_cd;

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign o_key[g] = i_cd[c_pc2[g] - 1];
  end

  // CD bits 9,18,22,25,35,38,43,54 are dropped by PC-2
  assign w_unused_cd = ^{i_cd[53], i_cd[42], i_cd[37], i_cd[34],
                         i_cd[24], i_cd[21], i_cd[17], i_cd[8]};
endmodule

module des_key_sched_ctrl #(
  parameter logic [15:0] ONE_SHIFT_MASK = 16'h8103
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        decrypt_i,
  input  logic [63:0] key_i,
  input  logic        abort_i,
  input  logic        key_ready_i,
  output logic [47:0] round_key_o,
  output logic [3:0]  round_idx_o,
  output logic        key_valid_o,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  state_t      r_state, w_state_nxt;
  logic [55:0] r_cd, w_cd_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_mode, w_mode_nxt;
  logic [55:0] w_pc1;
  logic        w_load_two, w_enc_two, w_dec_two;
  logic        w_unused_parity;

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign w_pc1[g] = key_i[c_pc1[g] - 1];
  end

  assign w_unused_parity = ^{key_i[63], key_i[55], key_i[47], key_i[39],
                             key_i[31], key_i[23], key_i[15], key_i[7]};

  // Rotations act on C = cd[27:0] and D = cd[55:28] independently
  function automatic logic [55:0] rot_left(input logic [55:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[27:0];
    d = cd[55:28];
    if (two) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {d, c};
  endfunction

  function automatic logic [55:0] rot_right(input logic [55:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[27:0];
    d = cd[55:28];
    if (two) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {d, c};
  endfunction

  // Encrypt steps into round idx+2; decrypt steps back from round 16-idx
  assign w_load_two = ~ONE_SHIFT_MASK[0];
  assign w_enc_two  = ~ONE_SHIFT_MASK[r_idx + 4'd1];
  assign w_dec_two  = ~ONE_SHIFT_MASK[4'd15 - r_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_mode_nxt  = decrypt_i;
            w_idx_nxt   = 4'd0;
            w_cd_nxt    = decrypt_i ? w_pc1 : rot_left(w_pc1, w_load_two);
            w_state_nxt = ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (key_ready_i) begin
            if (r_idx == 4'd15) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_idx_nxt = r_idx + 4'd1;
              w_cd_nxt  = r_mode ? rot_right(r_cd, w_dec_two) : rot_left(r_cd, w_enc_two);
            end
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cd    <= '0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  perm2 u_perm2 (
    .i_cd  (r_cd),
    .o_key (round_key_o)
  );

  assign round_idx_o = r_mode ? (4'd15 - r_idx) : r_idx;
  assign key_valid_o = (r_state == ST_ROUND);
  assign done_o      = (r_state == ST_DONE);
  assign busy_o      = (r_state != ST_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_des_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_sched_ctrl
// Purpose  : Scoreboard bench for des_key_sched_ctrl against a table-driven
//            DES key-schedule model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_des_key_sched_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        decrypt_i;
  logic [63:0] key_i;
  logic        abort_i;
  logic        key_ready_i;
  logic [47:0] round_key_o;
  logic [3:0]  round_idx_o;
  logic        key_valid_o;
  logic        busy_o;
  logic        done_o;

  des_key_sched_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .decrypt_i   (decrypt_i),
    .key_i       (key_i),
    .abort_i     (abort_i),
    .key_ready_i (key_ready_i),
    .round_key_o (round_key_o),
    .round_idx_o (round_idx_o),
    .key_valid_o (key_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          n_vec;
  int          n_err;
  logic        done_exp;
  logic        prev_stall;
  logic [47:0] prev_key;
  logic [3:0]  prev_idx;
  logic [63:0] kat_key;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] bitrev64(input logic [63:0] v);
    for (int i = 0; i < 64; i++) bitrev64[i] = v[63-i];
  endfunction

  function automatic logic [47:0] bitrev48(input logic [47:0] v);
    for (int i = 0; i < 48; i++) bitrev48[i] = v[47-i];
  endfunction

  // Round r key from the cumulative left shift applied to the PC-1 halves
  function automatic logic [47:0] subkey(input logic [63:0] key, input int r);
    logic [55:0] cd;
    int s;
    s = 0;
    for (int k = 0; k < r; k++) s += SHIFTS[k];
    for (int i = 0; i < 28; i++) begin
      cd[i]      = key[PC1[(i + s) % 28] - 1];
      cd[28 + i] = key[PC1[28 + (i + s) % 28] - 1];
    end
    for (int j = 0; j < 48; j++) subkey[j] = cd[PC2[j] - 1];
  endfunction

  // Monitor: pops on every accepted key, checks holds under stall and done timing
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_pulse", {63'd0, done_o}, {63'd0, done_exp});
      done_exp = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", {63'd0, key_valid_o}, 64'd1);
        chk("stall_key", {16'd0, round_key_o}, {16'd0, prev_key});
        chk("stall_idx", {60'd0, round_idx_o}, {60'd0, prev_idx});
      end
      if (key_valid_o) begin
        chk("busy_in_round", {63'd0, busy_o}, 64'd1);
        if (key_ready_i && !abort_i) begin
          if (q.size() == 0) begin
            chk("unexpected_key", {60'd0, round_idx_o}, 64'hFFFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("round_key", {16'd0, round_key_o}, {16'd0, e.key});
            chk("round_idx", {60'd0, round_idx_o}, {60'd0, e.idx});
            done_exp = e.last;
          end
        end
      end
      if (abort_i) q.delete();
      prev_stall = key_valid_o && !key_ready_i && !abort_i;
      prev_key   = round_key_o;
      prev_idx   = round_idx_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [63:0] key, input logic dec, input bit bp,
                     input int stop_at, input bit stop_rst, input bit kat, input bit poke);
    int   n_acc;
    int   stall;
    bit   finished;
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      int   r;
      r     = dec ? 16 - k : k + 1;
      e.key = subkey(key, r);
      if (kat && r == 1)  e.key = bitrev48(48'h1B02EFFC7072);
      if (kat && r == 2)  e.key = bitrev48(48'h79AED9DBC9E5);
      if (kat && r == 16) e.key = bitrev48(48'hCB3D8B0E17F5);
      e.idx  = 4'(r - 1);
      e.last = (k == 15);
      q.push_back(e);
    end
    start_i     = 1'b1;
    key_i       = key;
    decrypt_i   = dec;
    key_ready_i = 1'b1;
    abort_i     = 1'b0;
    tick();
    start_i  = 1'b0;
    n_acc    = 0;
    stall    = 0;
    finished = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (stop_at >= 0 && n_acc == stop_at && key_valid_o) begin
        finished = 1;
        if (stop_rst) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_valid", {63'd0, key_valid_o}, 64'd0);
          chk("rst_busy", {63'd0, busy_o}, 64'd0);
          chk("rst_done", {63'd0, done_o}, 64'd0);
          chk("rst_idx", {60'd0, round_idx_o}, 64'd0);
          chk("rst_key", {16'd0, round_key_o}, 64'd0);
          tick();
          rst_n = 1'b1;
        end else begin
          abort_i     = 1'b1;
          key_ready_i = 1'b1;
          tick();
          abort_i = 1'b0;
          chk("abort_valid", {63'd0, key_valid_o}, 64'd0);
          chk("abort_busy", {63'd0, busy_o}, 64'd0);
        end
      end else begin
        if (!bp) key_ready_i = 1'b1;
        else if (stall > 0) begin
          key_ready_i = 1'b0;
          stall--;
        end else if ($urandom_range(0, 2) == 0) begin
          key_ready_i = 1'b0;
          stall = 2;
        end else key_ready_i = 1'b1;
        if (poke) begin
          start_i   = 1'($urandom_range(0, 1));
          decrypt_i = 1'($urandom_range(0, 1));
          key_i     = {$urandom, $urandom};
        end
        @(negedge clk);
        if (key_valid_o && key_ready_i) n_acc++;
        if (done_o) begin
          if (poke) begin
            start_i   = 1'b1;
            decrypt_i = ~dec;
            key_i     = ~key;
          end
          tick();
          start_i = 1'b0;
          chk("idle_after_done", {63'd0, key_valid_o}, 64'd0);
          chk("busy_after_done", {63'd0, busy_o}, 64'd0);
          chk("keys_accepted", 64'(n_acc), 64'd16);
          chk("queue_drained", 64'(q.size()), 64'd0);
          finished = 1;
        end else begin
          tick();
        end
      end
    end
    if (!finished) chk("schedule_timeout", 64'(n_acc), 64'd16);
    start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rk;
    n_vec       = 0;
    n_err       = 0;
    done_exp    = 1'b0;
    prev_stall  = 1'b0;
    kat_key     = bitrev64(64'h133457799BBCDFF1);
    rst_n       = 1'b0;
    start_i     = 1'b1;
    decrypt_i   = 1'b0;
    key_i       = kat_key;
    abort_i     = 1'b0;
    key_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, key_valid_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_done", {63'd0, done_o}, 64'd0);
    chk("reset_idx", {60'd0, round_idx_o}, 64'd0);
    chk("reset_key", {16'd0, round_key_o}, 64'd0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_reset_valid", {63'd0, key_valid_o}, 64'd0);
      chk("post_reset_busy", {63'd0, busy_o}, 64'd0);
      chk("post_reset_idx", {60'd0, round_idx_o}, 64'd0);
    end

    run(kat_key, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    run(kat_key, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    run(kat_key, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0);

    rk = {$urandom, $urandom};
    run(rk, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0);
    run(rk, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    run({$urandom, $urandom}, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1);
    run({$urandom, $urandom}, 1'b0, 1'b0, 9, 1'b1, 1'b0, 1'b0);
    run(kat_key, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      run({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          -1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
